// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, mid-bit start check, one sample per bit,
// one-cycle strobes for good words and for frames whose stop bit is low.
module uart_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_frame_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        START_BIT       = 3'd1,
        DATA_BITS_STATE = 3'd2,
        STOP_BIT        = 3'd3,
        BREAK_WAIT      = 3'd4
    } state_t;

    logic [1:0]           sync_reg;
    logic                 rx_sync;
    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     clk_count_reg, clk_count_next;
    logic [IDX_W-1:0]     bit_index_reg, bit_index_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
    logic                 rx_valid_reg, rx_valid_next;
    logic                 rx_frame_err_reg, rx_frame_err_next;
    logic                 capture;

    assign rx_sync = sync_reg[1];

    // Each shift-register bit loads only when its own index is being sampled.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        assign shift_next[gi] = (capture && (bit_index_reg == IDX_W'(gi))) ? rx_sync : shift_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg         <= 2'b11;
            state_reg        <= IDLE;
            clk_count_reg    <= '0;
            bit_index_reg    <= '0;
            shift_reg        <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            rx_frame_err_reg <= 1'b0;
        end else begin
            sync_reg         <= {sync_reg[0], rx_serial};
            state_reg        <= state_next;
            clk_count_reg    <= clk_count_next;
            bit_index_reg    <= bit_index_next;
            shift_reg        <= shift_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            rx_frame_err_reg <= rx_frame_err_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        clk_count_next    = clk_count_reg;
        bit_index_next    = bit_index_reg;
        rx_data_next      = rx_data_reg;
        rx_valid_next     = 1'b0;
        rx_frame_err_next = 1'b0;
        capture           = 1'b0;

        case (state_reg)
            IDLE: begin
                clk_count_next = '0;
                bit_index_next = '0;
                if (!rx_sync) state_next = START_BIT;
            end
            START_BIT: begin
                if (clk_count_reg == CNT_HALF) begin
                    clk_count_next = '0;
                    // A line that is already high again at mid-bit was only a glitch.
                    state_next = rx_sync ? IDLE : DATA_BITS_STATE;
                end else begin
                    clk_count_next = clk_count_reg + 1'b1;
                end
            end
            DATA_BITS_STATE: begin
                if (clk_count_reg == CNT_LAST) begin
                    clk_count_next = '0;
                    capture        = 1'b1;
                    if (bit_index_reg == IDX_LAST) begin
                        bit_index_next = '0;
                        state_next     = STOP_BIT;
                    end else begin
                        bit_index_next = bit_index_reg + 1'b1;
                    end
                end else begin
                    clk_count_next = clk_count_reg + 1'b1;
                end
            end
            STOP_BIT: begin
                if (clk_count_reg == CNT_LAST) begin
                    clk_count_next = '0;
                    if (rx_sync) begin
                        rx_data_next  = shift_reg;
                        rx_valid_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        rx_frame_err_next = 1'b1;
                        state_next        = BREAK_WAIT;
                    end
                end else begin
                    clk_count_next = clk_count_reg + 1'b1;
                end
            end
            BREAK_WAIT: begin
                // Hold off until the line idles so a long break is not read as a start bit.
                clk_count_next = '0;
                if (rx_sync) state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                clk_count_next = '0;
                bit_index_next = '0;
            end
        endcase
    end

    assign rx_data      = rx_data_reg;
    assign rx_valid     = rx_valid_reg;
    assign rx_frame_err = rx_frame_err_reg;
    assign rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural serial transmitter drives 8-bit and 7-bit receivers,
// received strobes are logged with their cycle and compared with frame-level expectations.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_HZ = 1_843_200;
    localparam int BAUD   = 115200;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = (CPB - 1) / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       rx_line8 = 1'b1;
    logic       rx_line7 = 1'b1;
    logic [7:0] rx_data8;
    logic       rx_valid8, rx_busy8, rx_err8;
    logic [6:0] rx_data7;
    logic       rx_valid7, rx_busy7, rx_err7;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .rx_serial(rx_line8), .rx_data(rx_data8),
        .rx_valid(rx_valid8), .rx_busy(rx_busy8), .rx_frame_err(rx_err8)
    );

    uart_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7)) dut7 (
        .clk(clk), .rst(rst), .rx_serial(rx_line7), .rx_data(rx_data7),
        .rx_valid(rx_valid7), .rx_busy(rx_busy7), .rx_frame_err(rx_err7)
    );

    // kind 1 = good word, kind 2 = framing error
    typedef struct { int kind; int data; int c; } ev_t;
    ev_t evq8[$];
    ev_t evq7[$];

    always @(negedge clk) begin
        if (rx_valid8) evq8.push_back('{kind: 1, data: int'(rx_data8), c: cyc});
        if (rx_err8)   evq8.push_back('{kind: 2, data: int'(rx_data8), c: cyc});
        if (rx_valid7) evq7.push_back('{kind: 1, data: int'(rx_data7), c: cyc});
        if (rx_err7)   evq7.push_back('{kind: 2, data: int'(rx_data7), c: cyc});
    end

    // Line driven at negedge cycle s: two synchroniser edges plus the IDLE edge give t = s+3;
    // the strobe is visible one cycle after the stop-bit sample at t+1+HALF+(N+1)*CPB.
    function automatic int exp_cyc(input int s, input int nbits);
        return s + 4 + HALF + (nbits + 1) * CPB;
    endfunction

    task automatic set_line(input int which, input logic v);
        if (which == 8) rx_line8 = v;
        else            rx_line7 = v;
    endtask

    task automatic hold(input int which, input logic v, input int n);
        @(negedge clk);
        set_line(which, v);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input int data, input int nbits,
                              input logic stop, output int s);
        @(negedge clk);
        set_line(which, 1'b0);
        s = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < nbits; i++) hold(which, data[i], CPB);
        hold(which, stop, CPB);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (rx_data8 !== 8'h00) begin miscompares++; $display("FAIL reset_data8: got %0h want 0", rx_data8); end
        vectors++; if (rx_valid8 !== 1'b0) begin miscompares++; $display("FAIL reset_valid8: got %0b want 0", rx_valid8); end
        vectors++; if (rx_err8 !== 1'b0) begin miscompares++; $display("FAIL reset_err8: got %0b want 0", rx_err8); end
        vectors++; if (rx_busy8 !== 1'b0) begin miscompares++; $display("FAIL reset_busy8: got %0b want 0", rx_busy8); end
        vectors++; if (rx_data7 !== 7'h00) begin miscompares++; $display("FAIL reset_data7: got %0h want 0", rx_data7); end
        vectors++; if (rx_busy7 !== 1'b0) begin miscompares++; $display("FAIL reset_busy7: got %0b want 0", rx_busy7); end
        $display("reset: done, vectors=%0d", vectors);
    endtask

    task automatic test_single_frame;
        int s0, s, e;
        evq8.delete();
        s0 = cyc + 1;
        e = exp_cyc(s0, 8);
        fork
            send_frame(8, 'hA5, 8, 1'b1, s);
            begin
                wait_until(s0 + 100);
                vectors++; if (rx_busy8 !== 1'b1) begin miscompares++; $display("FAIL single_busy_mid: got %0b want 1", rx_busy8); end
                wait_until(e);
                vectors++; if (rx_valid8 !== 1'b1) begin miscompares++; $display("FAIL single_valid_at_t: got %0b want 1", rx_valid8); end
                vectors++; if (rx_busy8 !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %0b want 0", rx_busy8); end
                wait_until(e + 1);
                vectors++; if (rx_valid8 !== 1'b0) begin miscompares++; $display("FAIL single_valid_width: got %0b want 0", rx_valid8); end
            end
        join
        wait_until(e + 20);
        vectors++; if (evq8.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", evq8.size()); end
        if (evq8.size() >= 1) begin
            vectors++; if (evq8[0].kind != 1 || evq8[0].data != 'hA5) begin miscompares++; $display("FAIL single_word: got kind %0d data %0h want kind 1 data a5", evq8[0].kind, evq8[0].data); end
            vectors++; if (evq8[0].c != e) begin miscompares++; $display("FAIL single_time: got %0d want %0d", evq8[0].c, e); end
        end
        $display("single 0xA5: events=%0d", evq8.size());
    endtask

    task automatic test_glitch;
        int bc = 0;
        evq8.delete();
        @(negedge clk);
        rx_line8 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rx_busy8) bc++;
            if (i == 4) rx_line8 = 1'b1;
        end
        vectors++; if (bc != HALF + 1) begin miscompares++; $display("FAIL glitch_busy_cycles: got %0d want %0d", bc, HALF + 1); end
        vectors++; if (evq8.size() != 0) begin miscompares++; $display("FAIL glitch_events: got %0d want 0", evq8.size()); end
        vectors++; if (rx_busy8 !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: got %0b want 0", rx_busy8); end
        $display("glitch: busy cycles=%0d", bc);
    endtask

    task automatic test_break(input int prev_word);
        int s, e;
        evq8.delete();
        send_frame(8, 'h3C, 8, 1'b0, s);
        e = exp_cyc(s, 8);
        hold(8, 1'b0, 40 * CPB);
        vectors++; if (rx_busy8 !== 1'b1) begin miscompares++; $display("FAIL break_busy: got %0b want 1", rx_busy8); end
        vectors++; if (evq8.size() != 1) begin miscompares++; $display("FAIL break_count_low: got %0d want 1", evq8.size()); end
        hold(8, 1'b1, 200);
        vectors++; if (evq8.size() != 1) begin miscompares++; $display("FAIL break_count_after: got %0d want 1", evq8.size()); end
        if (evq8.size() >= 1) begin
            vectors++; if (evq8[0].kind != 2 || evq8[0].c != e) begin miscompares++; $display("FAIL break_err_pulse: got kind %0d at %0d want kind 2 at %0d", evq8[0].kind, evq8[0].c, e); end
        end
        vectors++; if (int'(rx_data8) != prev_word) begin miscompares++; $display("FAIL break_data_held: got %0h want %0h", rx_data8, prev_word); end
        vectors++; if (rx_busy8 !== 1'b0) begin miscompares++; $display("FAIL break_idle: got %0b want 0", rx_busy8); end
        $display("break 0x3C: events=%0d data=%0h", evq8.size(), rx_data8);
    endtask

    task automatic test_back_to_back;
        int s1, s2;
        evq8.delete();
        send_frame(8, 'h00, 8, 1'b1, s1);
        send_frame(8, 'hFF, 8, 1'b1, s2);
        wait_until(exp_cyc(s2, 8) + 20);
        vectors++; if (s2 - s1 != 10 * CPB) begin miscompares++; $display("FAIL b2b_gap_stim: got %0d want %0d", s2 - s1, 10 * CPB); end
        vectors++; if (evq8.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", evq8.size()); end
        if (evq8.size() == 2) begin
            vectors++; if (evq8[0].kind != 1 || evq8[0].data != 'h00 || evq8[0].c != exp_cyc(s1, 8)) begin miscompares++; $display("FAIL b2b_first: got kind %0d data %0h at %0d want 1 00 at %0d", evq8[0].kind, evq8[0].data, evq8[0].c, exp_cyc(s1, 8)); end
            vectors++; if (evq8[1].kind != 1 || evq8[1].data != 'hFF || evq8[1].c != exp_cyc(s2, 8)) begin miscompares++; $display("FAIL b2b_second: got kind %0d data %0h at %0d want 1 ff at %0d", evq8[1].kind, evq8[1].data, evq8[1].c, exp_cyc(s2, 8)); end
            vectors++; if (evq8[1].c - evq8[0].c != 160) begin miscompares++; $display("FAIL b2b_spacing: got %0d want 160", evq8[1].c - evq8[0].c); end
        end
        $display("back-to-back 0x00,0xFF: events=%0d", evq8.size());
    endtask

    task automatic test_reset_mid_frame;
        int s;
        int w = 'h55;
        evq8.delete();
        hold(8, 1'b0, CPB);
        for (int i = 0; i < 3; i++) hold(8, w[i], CPB);
        hold(8, w[3], CPB / 2);
        @(negedge clk);
        rst = 1'b1;
        rx_line8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (rx_busy8 !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %0b want 0", rx_busy8); end
        vectors++; if (rx_data8 !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %0h want 0", rx_data8); end
        repeat (40) @(negedge clk);
        vectors++; if (evq8.size() != 0) begin miscompares++; $display("FAIL midrst_no_output: got %0d want 0", evq8.size()); end
        send_frame(8, 'h81, 8, 1'b1, s);
        wait_until(exp_cyc(s, 8) + 20);
        vectors++; if (evq8.size() != 1) begin miscompares++; $display("FAIL midrst_count: got %0d want 1", evq8.size()); end
        if (evq8.size() >= 1) begin
            vectors++; if (evq8[0].kind != 1 || evq8[0].data != 'h81) begin miscompares++; $display("FAIL midrst_word: got kind %0d data %0h want 1 81", evq8[0].kind, evq8[0].data); end
        end
        $display("reset mid-frame then 0x81: events=%0d", evq8.size());
    endtask

    task automatic test_loopback;
        int exp8[$], st8[$], exp7[$], st7[$];
        int last;
        evq8.delete();
        evq7.delete();
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    int d8, g8, s8;
                    d8 = int'($urandom_range(0, 255));
                    g8 = int'($urandom_range(0, 3));
                    if (g8 > 0) hold(8, 1'b1, g8);
                    send_frame(8, d8, 8, 1'b1, s8);
                    exp8.push_back(d8);
                    st8.push_back(s8);
                end
            end
            begin
                for (int i = 0; i < 256; i++) begin
                    int d7, g7, s7;
                    d7 = int'($urandom_range(0, 127));
                    g7 = int'($urandom_range(0, 3));
                    if (g7 > 0) hold(7, 1'b1, g7);
                    send_frame(7, d7, 7, 1'b1, s7);
                    exp7.push_back(d7);
                    st7.push_back(s7);
                end
            end
        join
        last = cyc;
        wait_until(last + 4 * CPB);
        vectors++; if (evq8.size() != 256) begin miscompares++; $display("FAIL loop8_count: got %0d want 256", evq8.size()); end
        vectors++; if (evq7.size() != 256) begin miscompares++; $display("FAIL loop7_count: got %0d want 256", evq7.size()); end
        for (int i = 0; i < 256 && i < evq8.size(); i++) begin
            vectors++;
            if (evq8[i].kind != 1 || evq8[i].data != exp8[i] || evq8[i].c != exp_cyc(st8[i], 8)) begin
                miscompares++;
                $display("FAIL loop8_word%0d: got kind %0d data %0h at %0d want 1 %0h at %0d", i, evq8[i].kind, evq8[i].data, evq8[i].c, exp8[i], exp_cyc(st8[i], 8));
            end
        end
        for (int i = 0; i < 256 && i < evq7.size(); i++) begin
            vectors++;
            if (evq7[i].kind != 1 || evq7[i].data != exp7[i] || evq7[i].c != exp_cyc(st7[i], 7)) begin
                miscompares++;
                $display("FAIL loop7_word%0d: got kind %0d data %0h at %0d want 1 %0h at %0d", i, evq7[i].kind, evq7[i].data, evq7[i].c, exp7[i], exp_cyc(st7[i], 7));
            end
        end
        $display("loopback: 8-bit events=%0d, 7-bit events=%0d", evq8.size(), evq7.size());
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_break('hA5);
        test_back_to_back();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
